program_loader: RTL

Loads a program image into the microcontroller's 256 x 8 program memory from a byte stream. It holds the core in reset while loading and releases it only after a verified image. It is the write side of program memory, while the program sequencer is the read side. It sits beside `micro`: its write port muxes into program memory, and `micro_hold` is ORed into the core's reset.

---
 rtl/micro_pkg.sv | 20 ++
 rtl/loader_timeout.sv | 39 +++
 rtl/program_loader.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/micro_pkg.sv
// Shared types for the microcontroller's program-memory loader.
// Loader FSM states, sticky error codes and program memory depth.
package micro_pkg;

   localparam int PM_DEPTH = 256;

   typedef enum logic [2:0] {
      IDLE,
      LEN,
      DATA,
      CHK,
      DONE,
      ERR
   } ld_state_e;

   localparam logic [1:0] ERR_NONE     = 2'b00;
   localparam logic [1:0] ERR_CHECKSUM = 2'b01;
   localparam logic [1:0] ERR_TIMEOUT  = 2'b10;

endpackage

// File: rtl/loader_timeout.sv
// Saturating idle counter: expired is high during the TIMEOUT_CYC-th consecutive enabled cycle,
// so the FSM leaves on the edge where the count would reach TIMEOUT_CYC.
module loader_timeout #(
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic clk,
   input  logic reset,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(TIMEOUT_CYC - 1);
   localparam logic [CNT_W-1:0] SAT  = CNT_W'(TIMEOUT_CYC);

   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (clear) begin
         cnt_d = '0;
      end else if (enable && (cnt_q != SAT)) begin
         cnt_d = cnt_q + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign expired = enable && !clear && (cnt_q >= LAST);

endmodule

// File: rtl/program_loader.sv
// Loads a length-prefixed, checksummed byte stream into program memory, holding the core
// in reset until a session verifies; one write per accepted image byte, one cycle later.
module program_loader
   import micro_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 8,
   parameter int TIMEOUT_CYC = 1023
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              rx_valid,
   input  logic [DATA_W-1:0] rx_data,
   output logic              rx_ready,
   output logic [ADDR_W-1:0] pm_address,
   output logic [DATA_W-1:0] pm_data,
   output logic              pm_wren,
   output logic              micro_hold,
   output logic              busy,
   output logic              done,
   output logic [1:0]        error_code
);

   ld_state_e         state_q, state_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [ADDR_W-1:0] rem_q, rem_d;
   logic [DATA_W-1:0] sum_q, sum_d;
   logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
   logic [DATA_W-1:0] wr_data_q, wr_data_d;
   logic              wren_q, wren_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic [1:0]        err_q, err_d;

   logic              in_session;
   logic              xfer;
   logic              expired;
   logic [DATA_W-1:0] chk_sum;

   assign in_session = (state_q == LEN) || (state_q == DATA) || (state_q == CHK);
   assign xfer       = rx_valid && in_session;
   assign chk_sum    = sum_q + rx_data;

   loader_timeout #(
      .TIMEOUT_CYC(TIMEOUT_CYC)
   ) u_timeout (
      .clk    (clk),
      .reset  (reset),
      .clear  (!in_session || xfer),
      .enable (in_session && !xfer),
      .expired(expired)
   );

   always_comb begin
      state_d   = state_q;
      addr_d    = addr_q;
      rem_d     = rem_q;
      sum_d     = sum_q;
      wr_addr_d = wr_addr_q;
      wr_data_d = wr_data_q;
      wren_d    = 1'b0;
      hold_d    = hold_q;
      done_d    = done_q;
      err_d     = err_q;

      case (state_q)
         IDLE, DONE, ERR: begin
            if (start) begin
               state_d = LEN;
               addr_d  = '0;
               rem_d   = '0;
               sum_d   = '0;
               hold_d  = 1'b1;
               done_d  = 1'b0;
               err_d   = ERR_NONE;
            end
         end
         LEN: begin
            if (xfer) begin
               state_d = DATA;
               rem_d   = ADDR_W'(rx_data);
            end else if (expired) begin
               state_d = ERR;
               err_d   = ERR_TIMEOUT;
            end
         end
         DATA: begin
            if (xfer) begin
               wren_d    = 1'b1;
               wr_addr_d = addr_q;
               wr_data_d = rx_data;
               addr_d    = addr_q + 1'b1;
               sum_d     = sum_q + rx_data;
               if (rem_q == '0) begin
                  state_d = CHK;
               end else begin
                  rem_d = rem_q - 1'b1;
               end
            end else if (expired) begin
               state_d = ERR;
               err_d   = ERR_TIMEOUT;
            end
         end
         CHK: begin
            if (xfer) begin
               // Failed images keep the core held; only a later passing session releases it.
               if (chk_sum == '0) begin
                  state_d = DONE;
                  done_d  = 1'b1;
                  hold_d  = 1'b0;
               end else begin
                  state_d = ERR;
                  err_d   = ERR_CHECKSUM;
               end
            end else if (expired) begin
               state_d = ERR;
               err_d   = ERR_TIMEOUT;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q   <= IDLE;
         addr_q    <= '0;
         rem_q     <= '0;
         sum_q     <= '0;
         wr_addr_q <= '0;
         wr_data_q <= '0;
         wren_q    <= 1'b0;
         hold_q    <= 1'b0;
         done_q    <= 1'b0;
         err_q     <= ERR_NONE;
      end else begin
         state_q   <= state_d;
         addr_q    <= addr_d;
         rem_q     <= rem_d;
         sum_q     <= sum_d;
         wr_addr_q <= wr_addr_d;
         wr_data_q <= wr_data_d;
         wren_q    <= wren_d;
         hold_q    <= hold_d;
         done_q    <= done_d;
         err_q     <= err_d;
      end
   end

   assign rx_ready   = in_session;
   assign busy       = in_session;
   assign pm_address = wr_addr_q;
   assign pm_data    = wr_data_q;
   assign pm_wren    = wren_q;
   assign micro_hold = hold_q;
   assign done       = done_q;
   assign error_code = err_q;

endmodule
